// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial adder controller.
// Nibble select works on a fixed maximum width so one function serves any WIDTH.
package nibble_serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;
   localparam int MAX_W    = 1024;

   function automatic logic [NIBBLE_W-1:0] nibble_sel(input logic [MAX_W-1:0] v,
                                                      input int unsigned i);
      return v[NIBBLE_W*i +: NIBBLE_W];
   endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/response bundle between operand producers, the controller and the consumer.
// Both channels: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface nibble_serial_adder_ctrl_if #(parameter int WIDTH = 16);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, busy
   );

endinterface

// File: rtl/nibble_serial_adder_ctrl_cla4.sv
// Combinational 4-bit carry-lookahead slice shared by the serial controller.
module cla4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       cin,
   output logic [3:0] z,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = x & y;
   assign p = x ^ y;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign z    = p ^ c[3:0];
   assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit add/subtract: one nibble per cycle through a single cla4,
// LS nibble first, with the inter-nibble carry held in a register.
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             res,
   nibble_serial_adder_ctrl_if.slave        bus,
   output state_t                           dbg_state
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic                 carry;
   logic [WIDTH-1:0]     opa;
   logic [WIDTH-1:0]     opb;
   logic [WIDTH-1:0]     sum_q;
   logic                 cout_q;
   logic                 ovf_q;
   logic                 out_valid_q;
   logic [NIBBLE_W-1:0]  x;
   logic [NIBBLE_W-1:0]  y;
   logic [NIBBLE_W-1:0]  z;
   logic                 slice_cout;

   assign x = nibble_sel(MAX_W'(opa), 32'(idx));
   assign y = nibble_sel(MAX_W'(opb), 32'(idx));

   cla4 u_cla4 (
      .x    (x),
      .y    (y),
      .cin  (carry),
      .z    (z),
      .cout (slice_cout)
   );

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state       <= IDLE;
         idx         <= '0;
         carry       <= 1'b0;
         opa         <= '0;
         opb         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  // Subtract is A + ~B + 1; the caller's cin is meaningless then.
                  opa   <= bus.a;
                  opb   <= bus.sub ? ~bus.b : bus.b;
                  carry <= bus.sub ? 1'b1 : bus.cin;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum_q[NIBBLE_W*idx +: NIBBLE_W] <= z;
               carry <= slice_cout;
               if (idx == LAST_IDX) begin
                  cout_q      <= slice_cout;
                  ovf_q       <= (opa[WIDTH-1] == opb[WIDTH-1]) && (z[NIBBLE_W-1] != opa[WIDTH-1]);
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign dbg_state     = state;

endmodule
